// File: rtl/irq_pend_arb.sv
// Interrupt pending/priority stage: latches edge- or level-type requests, picks the
// lowest pending index and runs a req/ack/EOI handshake with the CPU (no nesting).
module irq_pend_arb #(
    parameter int          CIrqCnt   = 16,
    parameter logic [15:0] CEdgeMask = 16'hFFFF
) (
    input  logic               AClkH,
    input  logic               AResetH,
    input  logic               AClkHEn,
    input  logic [CIrqCnt-1:0] AIrqI,
    input  logic               AIrqAck,
    input  logic               AIrqEoi,
    output logic               AIrqReq,
    output logic [3:0]         AIrqVec,
    output logic [CIrqCnt-1:0] AIrqPend,
    output logic               AIrqBusy,
    output logic [7:0]         ATest
);

    localparam logic [1:0] SIdle = 2'd0;
    localparam logic [1:0] SReq  = 2'd1;
    localparam logic [1:0] SServ = 2'd2;

    localparam logic [CIrqCnt-1:0] CEdgeLines = CEdgeMask[CIrqCnt-1:0];

    logic [CIrqCnt-1:0] FIrqPrev;
    logic [CIrqCnt-1:0] FPend;
    logic [1:0]         FState;
    logic [3:0]         FVec;

    logic [1:0]         stateNxt;
    logic [3:0]         vecNxt;
    logic [3:0]         winVec;
    logic               ackTake;
    logic [CIrqCnt-1:0] ackClr;
    logic [CIrqCnt-1:0] pendNxt;

    always_ff @(posedge AClkH or posedge AResetH) begin
        if (AResetH) begin
            FIrqPrev <= '0;
            FPend    <= '0;
            FState   <= SIdle;
            FVec     <= '0;
        end else if (AClkHEn) begin
            FIrqPrev <= AIrqI;
            FPend    <= pendNxt;
            FState   <= stateNxt;
            FVec     <= vecNxt;
        end
    end

    // Fixed priority: scanning downward lets the lowest set index win.
    always_comb begin
        winVec = '0;
        for (int i = CIrqCnt - 1; i >= 0; i--) begin
            if (FPend[i]) winVec = 4'(i);
        end
    end

    always_comb begin
        stateNxt = FState;
        vecNxt   = FVec;
        ackTake  = 1'b0;
        case (FState)
            SIdle: begin
                if (|FPend) begin
                    vecNxt   = winVec;
                    stateNxt = SReq;
                end
            end
            SReq: begin
                if (AIrqAck) begin
                    ackTake  = 1'b1;
                    stateNxt = SServ;
                end
            end
            SServ: begin
                if (AIrqEoi) stateNxt = SIdle;
            end
            default: stateNxt = SIdle;
        endcase
    end

    // A new edge in the ack cycle is OR-ed in after the clear, so set wins.
    always_comb begin
        ackClr = '0;
        for (int i = 0; i < CIrqCnt; i++) begin
            ackClr[i] = ackTake && (FVec == 4'(i));
        end
        pendNxt = ((FPend & ~ackClr) & CEdgeLines)
                | (AIrqI & ~FIrqPrev & CEdgeLines)
                | (AIrqI & ~CEdgeLines);
    end

    always_comb begin
        AIrqReq  = (FState == SReq);
        AIrqBusy = (FState == SServ);
        AIrqVec  = FVec;
        AIrqPend = FPend;
        ATest    = {FState, 2'b00, FVec};
    end

endmodule

// File: tb/tb_irq_pend_arb.sv
// Directed bench for irq_pend_arb: 16 lines, line 2 level-sensitive, all others edge.
module tb_irq_pend_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] irq;
    logic        ack;
    logic        eoi;
    logic        req;
    logic [3:0]  vec;
    logic [15:0] pend;
    logic        busy;
    logic [7:0]  test;

    int checks = 0;
    int failures = 0;

    irq_pend_arb #(.CIrqCnt(16), .CEdgeMask(16'hFFFB)) dut (
        .AClkH(clk), .AResetH(rst), .AClkHEn(en), .AIrqI(irq),
        .AIrqAck(ack), .AIrqEoi(eoi), .AIrqReq(req), .AIrqVec(vec),
        .AIrqPend(pend), .AIrqBusy(busy), .ATest(test)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; irq = '0; ack = 1'b0; eoi = 1'b0;
        tick(); tick();
        chk("rst_req", 32'(req), 0);
        chk("rst_pend", 32'(pend), 0);
        chk("rst_test", 32'(test), 0);
        rst = 1'b0;
        tick();

        // single edge line 5
        irq = 16'h0020; tick(); irq = '0;
        chk("e5_pend", 32'(pend), 32'h0020);
        chk("e5_noreq", 32'(req), 0);
        tick();
        chk("e5_req", 32'(req), 1);
        chk("e5_vec", 32'(vec), 5);
        chk("e5_test", 32'(test), 32'h45);
        ack = 1'b1; tick(); ack = 1'b0;
        chk("e5_ack_req", 32'(req), 0);
        chk("e5_ack_busy", 32'(busy), 1);
        chk("e5_ack_pend", 32'(pend), 0);
        eoi = 1'b1; tick(); eoi = 1'b0;
        chk("e5_eoi_busy", 32'(busy), 0);
        tick();
        chk("e5_eoi_req", 32'(req), 0);

        // priority 9 and 3, then line 1 during Req
        irq = 16'h0208; tick(); irq = '0;
        chk("pr_pend", 32'(pend), 32'h0208);
        tick();
        chk("pr_vec3", 32'(vec), 3);
        irq = 16'h0002; tick(); irq = '0;
        chk("pr_hold_vec", 32'(vec), 3);
        chk("pr_hold_req", 32'(req), 1);
        chk("pr_hold_pend", 32'(pend), 32'h020A);
        ack = 1'b1; tick(); ack = 1'b0;
        chk("pr_ack_pend", 32'(pend), 32'h0202);
        eoi = 1'b1; tick(); eoi = 1'b0;
        tick();
        chk("pr_vec1_req", 32'(req), 1);
        chk("pr_vec1", 32'(vec), 1);
        ack = 1'b1; tick(); ack = 1'b0;
        eoi = 1'b1; tick(); eoi = 1'b0;
        tick();
        chk("pr_vec9", 32'(vec), 9);
        chk("pr_vec9_req", 32'(req), 1);
        ack = 1'b1; tick(); ack = 1'b0;
        eoi = 1'b1; tick(); eoi = 1'b0;
        chk("pr_done_pend", 32'(pend), 0);

        // level line 2 dropped before EOI
        irq = 16'h0004; tick();
        chk("lv_pend", 32'(pend), 32'h0004);
        tick();
        chk("lv_vec", 32'(vec), 2);
        ack = 1'b1; tick(); ack = 1'b0;
        chk("lv_ack_pend", 32'(pend), 32'h0004);
        chk("lv_ack_busy", 32'(busy), 1);
        irq = '0; tick();
        chk("lv_drop_pend", 32'(pend), 0);
        eoi = 1'b1; tick(); eoi = 1'b0;
        tick();
        chk("lv_no_rereq", 32'(req), 0);

        // level line 2 held through EOI
        irq = 16'h0004; tick(); tick();
        chk("lv2_req", 32'(req), 1);
        ack = 1'b1; tick(); ack = 1'b0;
        eoi = 1'b1; tick(); eoi = 1'b0;
        chk("lv2_eoi_req", 32'(req), 0);
        tick();
        chk("lv2_rereq", 32'(req), 1);
        chk("lv2_rereq_vec", 32'(vec), 2);
        ack = 1'b1; tick(); ack = 1'b0;
        irq = '0;
        eoi = 1'b1; tick(); eoi = 1'b0;
        chk("lv2_end_pend", 32'(pend), 0);

        // edge on line 4 coinciding with ack of vector 4
        irq = 16'h0010; tick(); irq = '0; tick();
        chk("bd_vec4", 32'(vec), 4);
        ack = 1'b1; irq = 16'h0010; tick(); ack = 1'b0; irq = '0;
        chk("bd_setwins", 32'(pend), 32'h0010);
        chk("bd_busy", 32'(busy), 1);
        eoi = 1'b1; tick(); eoi = 1'b0;
        tick();
        chk("bd_rereq", 32'(req), 1);
        chk("bd_rereq_vec", 32'(vec), 4);
        ack = 1'b1; eoi = 1'b1; tick(); ack = 1'b0; eoi = 1'b0;
        chk("bd_ackeoi_busy", 32'(busy), 1);
        chk("bd_ackeoi_pend", 32'(pend), 0);
        tick();
        chk("bd_still_serv", 32'(test), 32'h84);
        eoi = 1'b1; tick(); eoi = 1'b0;
        ack = 1'b1; tick(); ack = 1'b0;
        chk("bd_idle_ack", 32'(test), 32'h04);
        chk("bd_idle_req", 32'(req), 0);

        // clock enable gating
        en = 1'b0; irq = 16'h0080; tick(); irq = '0; tick(); en = 1'b1; tick();
        chk("ce_missed_pend", 32'(pend), 0);
        chk("ce_missed_req", 32'(req), 0);
        irq = 16'h0001; tick(); irq = '0; tick();
        chk("ce_req", 32'(req), 1);
        en = 1'b0; ack = 1'b1; tick(); tick();
        chk("ce_frozen_req", 32'(req), 1);
        chk("ce_frozen_test", 32'(test), 32'h40);
        en = 1'b1; tick(); ack = 1'b0;
        chk("ce_ack_busy", 32'(busy), 1);
        eoi = 1'b1; tick(); eoi = 1'b0;

        // async reset in Serv with pending lines 0 and 8
        irq = 16'h0001; tick(); irq = '0; tick();
        ack = 1'b1; tick(); ack = 1'b0;
        irq = 16'h0101; tick(); irq = 16'h0001;
        chk("rs_pend", 32'(pend), 32'h0101);
        chk("rs_busy", 32'(busy), 1);
        #2 rst = 1'b1;
        #1;
        chk("rs_async_busy", 32'(busy), 0);
        chk("rs_async_pend", 32'(pend), 0);
        chk("rs_async_test", 32'(test), 0);
        chk("rs_async_req", 32'(req), 0);
        tick();
        rst = 1'b0;
        tick();
        chk("rs_rel_pend", 32'(pend), 32'h0001);
        chk("rs_rel_noreq", 32'(req), 0);
        tick();
        chk("rs_rel_req", 32'(req), 1);
        chk("rs_rel_vec", 32'(vec), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/irq_pend_arb.md
# irq_pend_arb

Interrupt pending/priority stage placed directly downstream of the per-line IRQ enable mask. It consumes the masked request lines and latches edge- or level-type pending bits. It selects the highest-priority pending line (lowest index) and presents a single request plus vector to the CPU core, using a request/acknowledge/end-of-interrupt handshake. Only one interrupt is in service at a time; there is no nesting.

## Interface
- CIrqCnt, 16, number of request lines (2..16).
- CEdgeMask, 16'hFFFF, per-line type: 1 = edge-triggered (rising), 0 = level-sensitive; bits above CIrqCnt-1 are ignored.
- AClkH  in  1  system clock, rising edge.
- AResetH  in  1  reset, asynchronous, active-high. One clock; reset is asynchronous and active-high.
- AClkHEn  in  1  clock enable; all state updates are gated by it.
- AIrqI  in  CIrqCnt  masked request lines from the enable-mask stage.
- AIrqAck  in  1  CPU accepts the presented vector.
- AIrqEoi  in  1  CPU signals end of service.
- AIrqReq  out  1  interrupt request to CPU (registered).
- AIrqVec  out  4  index of the requested line (registered); zero-extended when CIrqCnt < 16.
- AIrqPend  out  CIrqCnt  current pending bits (registered).
- AIrqBusy  out  1  high while in the Serv state.
- ATest  out  8  {FState[1:0], 2'b00, FVec[3:0]}.

## Operation
- Registers:
  - FIrqPrev: sampled copy of AIrqI.
  - FPend: pending bits.
  - FState: one of Idle=0, Req=1, Serv=2.
  - FVec: selected line index.
- Edge line i:
  - Set: FPend[i] sets when AIrqI[i] & ~FIrqPrev[i].
  - Clear: FPend[i] clears when an ack accepts vector i.
  - Simultaneous set and clear on the same line: set wins, so the bit stays 1.
- Level line i:
  - FPend[i] <= AIrqI[i] every enabled cycle.
  - An ack does not clear it; the source must drop the line before EOI.
- Priority: the lowest index among set FPend bits wins. This is a fixed priority; there is no round-robin.
- Idle:
  - If FPend != 0: FVec <= winning index, AIrqReq <= 1, go to Req.
  - Otherwise stay in Idle.
- Req:
  - AIrqReq and AIrqVec are held stable. FVec is not re-evaluated even if a higher-priority line becomes pending.
  - On AIrqAck: clear FPend[FVec] if it is an edge line, AIrqReq <= 0, go to Serv.
  - If a level line deasserts while in Req, the request is not withdrawn; the ack is honoured with the held vector.
- Serv:
  - AIrqBusy = 1.
  - On AIrqEoi, go to Idle. Pending bits keep accumulating in Serv.
- Ignored inputs:
  - AIrqAck outside Req is ignored.
  - AIrqEoi outside Serv is ignored.
  - AIrqAck and AIrqEoi together in Req: the ack is taken and the EOI is ignored.
- When AClkHEn = 0, all registers hold, and AIrqI edges occurring only during disabled cycles are missed.
- Encoding 3 of FState is illegal and recovers to Idle on the next enabled cycle.

## Timing
- Reset values (asserted asynchronously):
  - FIrqPrev=0, FPend=0, FState=Idle, FVec=0.
  - AIrqReq=0, AIrqVec=0, AIrqPend=0, AIrqBusy=0, ATest=0.
- Because FIrqPrev resets to 0, an edge line held high at reset release registers as one edge.
- Latency: AIrqI[i] rises before clock edge k → AIrqPend[i]=1 after k → AIrqReq=1 with AIrqVec=i after k+1 (2 enabled cycles).
- Ack sampled at edge m → AIrqReq=0, AIrqBusy=1, and pending clear after m.
- EOI sampled at edge p → Idle after p. If anything is pending, AIrqReq rises after p+1, so there is at least one idle cycle between services.
- Reset mid-handshake (Req or Serv) drops AIrqReq and AIrqBusy immediately and discards all pending bits.

## Test plan
- Single edge line: pulse AIrqI[5] for 1 cycle → AIrqPend=0x0020 one cycle later, AIrqReq=1 with AIrqVec=5 one cycle after that. Ack → AIrqPend=0, AIrqBusy=1. EOI → Idle, AIrqReq stays 0.
- Priority and hold: raise lines 9 and 3 together → vector 3. During Req, raise line 1 → vector stays 3. After ack and EOI, line 1 is served next, then line 9.
- Level line (CEdgeMask bit 2 = 0): hold AIrqI[2] high through ack → AIrqPend[2] stays 1. Drop it before EOI → no re-request. Keep it high through EOI → re-request with vector 2 two cycles later.
- Boundary events: an edge on line 4 in the same cycle as the ack of vector 4 → AIrqPend[4] stays 1 and line 4 is re-requested after EOI. Ack+EOI together in Req → Serv entered, AIrqBusy=1. Ack in Idle → no change.
- Clock enable: hold AClkHEn=0 across an AIrqI[7] pulse → no pending. With AClkHEn=0 during Req plus ack → state frozen, AIrqReq stays 1.
- Reset: assert AResetH in Serv with pending 0x0101 → all outputs 0 asynchronously. Release with AIrqI[0] held high (edge type) → AIrqReq=1 with vector 0 after 2 cycles.
